// File: rtl/blank_wait_arbiter.sv
// Round-robin arbiter that lends one shared blank/settle down-counter to NREQ requesters.
// The owner keeps grant for the whole wait and gets a single done pulse when it ends.
module blank_wait_arbiter #(
  parameter int NREQ    = 4,
  parameter int CNT_W   = 23,
  parameter int T_SHORT = 1000,
  parameter int T_LONG  = 6000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  len_long,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(T_SHORT - 1);
  localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(T_LONG - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state, state_n;
  logic [NREQ-1:0]  grant_n, done_n;
  logic [CNT_W-1:0] remaining_n;
  logic [IDX_W-1:0] last, last_n;
  logic [IDX_W-1:0] cand, winner;
  logic             found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      remaining <= '0;
      last      <= LAST_IDX;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      done      <= done_n;
      remaining <= remaining_n;
      last      <= last_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    done_n      = done;
    remaining_n = remaining;
    last_n      = last;
    found       = 1'b0;
    winner      = '0;
    cand        = last;

    // Walk one lap starting just after the previous winner; the first live request wins.
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          grant_n         = '0;
          grant_n[winner] = 1'b1;
          remaining_n     = len_long[winner] ? LOAD_LONG : LOAD_SHORT;
          last_n          = winner;
          state_n         = COUNT;
        end
      end
      COUNT: begin
        if (remaining != '0) begin
          remaining_n = remaining - 1'b1;
        end else begin
          done_n  = grant;
          grant_n = '0;
          state_n = DONE;
        end
      end
      DONE: begin
        done_n  = '0;
        state_n = IDLE;
      end
      default: begin
        grant_n     = '0;
        done_n      = '0;
        remaining_n = '0;
        state_n     = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_blank_wait_arbiter.sv
// Directed bench for blank_wait_arbiter with short waits (T_SHORT=5, T_LONG=12)
// plus a second two-requester instance exercising the one-cycle wait.
module tb_blank_wait_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req, len_long, grant, done;
  logic       busy;
  logic [7:0] remaining;

  logic [1:0] req2, len_long2, grant2, done2;
  logic       busy2;
  logic [3:0] remaining2;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int last_done_cyc = 0;
  int start_cyc [4];

  blank_wait_arbiter #(.NREQ(4), .CNT_W(8), .T_SHORT(5), .T_LONG(12)) dut (
    .clk(clk), .rst(rst), .req(req), .len_long(len_long),
    .grant(grant), .done(done), .busy(busy), .remaining(remaining)
  );

  blank_wait_arbiter #(.NREQ(2), .CNT_W(4), .T_SHORT(1), .T_LONG(3)) dut_t1 (
    .clk(clk), .rst(rst), .req(req2), .len_long(len_long2),
    .grant(grant2), .done(done2), .busy(busy2), .remaining(remaining2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Entered right after the grant edge; measures grant length, checks the done pulse,
  // then drops the owner's request and steps through the DONE cycle.
  task automatic watchWait(input string tag, input logic [3:0] owner, input int exp_len, input int drop_at);
    int n;
    n = 1;
    checkOutput({tag, "_grant"}, 32'(grant), 32'(owner));
    if (drop_at == 1) req = req & ~owner;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant != owner) break;
      n++;
      if (n == drop_at) req = req & ~owner;
    end
    checkOutput({tag, "_len"}, 32'(n), 32'(exp_len));
    checkOutput({tag, "_done"}, 32'(done), 32'(owner));
    checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    last_done_cyc = cyc;
    req = req & ~owner;
    tick();
    checkOutput({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  task automatic applyStimulus();
    // Reset state
    rst = 1'b1; req = '0; len_long = '0; req2 = '0; len_long2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rem", 32'(remaining), 32'd0);

    // Single short wait, len_long flipped after grant must not matter
    req = 4'b0001;
    tick();
    checkOutput("t1_grant", 32'(grant), 32'h1);
    checkOutput("t1_rem_load", 32'(remaining), 32'd4);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    len_long = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("t1_rem_step", 32'(remaining), 32'(4 - i));
      checkOutput("t1_grant_hold", 32'(grant), 32'h1);
    end
    tick();
    checkOutput("t1_done", 32'(done), 32'h1);
    checkOutput("t1_grant_off", 32'(grant), 32'h0);
    checkOutput("t1_rem_zero", 32'(remaining), 32'd0);
    req = '0; len_long = '0;
    tick();
    checkOutput("t1_done_clr", 32'(done), 32'h0);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // Long wait on requester 1, no re-grant once req is dropped
    req = 4'b0010; len_long = 4'b0010;
    tick();
    checkOutput("t2_rem_load", 32'(remaining), 32'd11);
    watchWait("t2", 4'b0010, 12, 0);
    checkOutput("t2_idle", 32'(busy), 32'd0);
    tick();
    checkOutput("t2_no_regrant", 32'(grant), 32'h0);

    // Async reset in the middle of a long wait
    req = 4'b0010;
    tick();
    repeat (5) tick();
    checkOutput("t5_rem_before", 32'(remaining), 32'd6);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_grant", 32'(grant), 32'h0);
    checkOutput("t5_done", 32'(done), 32'h0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_rem", 32'(remaining), 32'd0);
    req = '0; len_long = '0;
    tick();
    checkOutput("t5_no_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("t5_still_idle", 32'(done | grant), 32'h0);

    // All four requesting: order 0,1,2,3 with starts T_SHORT+2 apart
    req = 4'b1111;
    tick();
    start_cyc[0] = cyc;
    watchWait("t3_r0", 4'b0001, 5, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      start_cyc[k] = cyc;
      checkOutput("t3_spacing", 32'(start_cyc[k] - start_cyc[k-1]), 32'd7);
      watchWait("t3_rk", 4'(1 << k), 5, 0);
    end

    // Requester 2 drops mid-wait; pending requester 3 follows at done+2
    req = 4'b1100;
    tick();
    watchWait("t4_r2", 4'b0100, 5, 2);
    tick();
    checkOutput("t4_r3_grant", 32'(grant), 32'h8);
    checkOutput("t4_r3_gap", 32'(cyc - last_done_cyc), 32'd2);
    watchWait("t4_r3", 4'b1000, 5, 0);

    // One-cycle wait on the T_SHORT=1 instance
    req2 = 2'b01;
    tick();
    checkOutput("t1c_grant", 32'(grant2), 32'h1);
    checkOutput("t1c_rem", 32'(remaining2), 32'd0);
    tick();
    checkOutput("t1c_done", 32'(done2), 32'h1);
    checkOutput("t1c_grant_off", 32'(grant2), 32'h0);
    req2 = '0;
    tick();
    checkOutput("t1c_done_clr", 32'(done2), 32'h0);
    checkOutput("t1c_idle", 32'(busy2), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
